irq_controller: RTL and testbench

- Platform-side priority interrupt controller; the opposite end of the CPU exception unit's interrupt interface.
- Collects 16 interrupt sources, applies per-source mask and optional edge-trigger mode, and selects the highest-priority source.
- Drives a held request plus 4-bit vector toward the CPU, completes the handshake on acknowledge, and tracks the in-service source until software issues end-of-interrupt (EOI).
- Software programs it through a small register port.

---
 rtl/irq_controller.sv | 159 +++++++++++++++
 tb/tb_irq_controller.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller: 16-source priority interrupt controller with mask, request/ack handshake and EOI.
// Define IRQ_EDGE_TRIGGER_EN to build per-source edge-trigger mode (EDGE register, latched pending).
module irq_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] irqSources,
    output logic        interruptRequest,
    output logic [3:0]  interruptVector,
    input  logic        interruptAcknowledge,
    input  logic [3:0]  acknowledgeVector,
    input  logic [2:0]  regAddr,
    input  logic        regWrite,
    input  logic [15:0] regWriteData,
    output logic [15:0] regReadData
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [2:0] ADDR_MASK      = 3'd0;
    localparam logic [2:0] ADDR_PENDING   = 3'd1;
    localparam logic [2:0] ADDR_INSERVICE = 3'd2;
    localparam logic [2:0] ADDR_EOI       = 3'd3;
    localparam logic [2:0] ADDR_EDGE      = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;

    state_t                       state_q, state_d;
    logic [SYNC_STAGES-1:0][15:0] sync_q;
    logic [15:0]                  s, s_q;
    logic [15:0]                  mask_q, in_service_q, pending, candidate, edge_reg;
    logic [3:0]                   vector_q, winner;
    logic                         ack_error_q, eoi_q, ack_taken;
    logic                         write_mask, write_eoi, write_status;

    assign write_mask   = regWrite && (regAddr == ADDR_MASK);
    assign write_eoi    = regWrite && (regAddr == ADDR_EOI);
    assign write_status = regWrite && (regAddr == ADDR_STATUS);

    assign s = sync_q[SYNC_STAGES-1];

    // s_q is the level pending value and doubles as the previous-cycle copy for edge detection.
    // NOTE: every flop here, synchronizers included, is cleared by reset; there is no memory array to exempt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            s_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage capture the pre-edge value of the one before it.
            sync_q[0] <= irqSources;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_q <= s;
        end
    end

`ifdef IRQ_EDGE_TRIGGER_EN
    logic [15:0] edge_q, edge_pending_q, edge_clear;
    logic        write_pending, write_edge;

    assign write_pending = regWrite && (regAddr == ADDR_PENDING);
    assign write_edge    = regWrite && (regAddr == ADDR_EDGE);

    always_comb begin
        edge_clear = '0;
        if (write_pending) edge_clear = regWriteData;
        if (ack_taken)     edge_clear[acknowledgeVector] = 1'b1;
    end

    // A rising edge on the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_q         <= '0;
            edge_pending_q <= '0;
        end else begin
            if (write_edge) edge_q <= regWriteData;
            edge_pending_q <= ((edge_pending_q & ~edge_clear) | (s & ~s_q)) & edge_q;
        end
    end

    assign pending  = (edge_q & edge_pending_q) | (~edge_q & s_q);
    assign edge_reg = edge_q;
`else
    assign pending  = s_q;
    assign edge_reg = '0;
`endif

    assign candidate = pending & mask_q;

    // NOTE: winner gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        winner = '0;
        for (int i = 15; i >= 0; i--) begin
            if (candidate[i]) winner = 4'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_taken = 1'b0;
        unique case (state_q)
            IDLE:    if (candidate != '0) state_d = REQUEST;
            REQUEST: if (interruptAcknowledge) begin
                         state_d   = SERVICE;
                         ack_taken = 1'b1;
                     end
            SERVICE: if (eoi_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // EOI is registered, so the return to IDLE lands one edge after the write is captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            vector_q     <= '0;
            in_service_q <= '0;
            ack_error_q  <= 1'b0;
            eoi_q        <= 1'b0;
            mask_q       <= '0;
        end else begin
            state_q <= state_d;
            eoi_q   <= write_eoi && (state_q == SERVICE);
            if (write_mask) mask_q <= regWriteData;
            if (state_q == IDLE && state_d == REQUEST) vector_q <= winner;
            if (ack_taken) begin
                in_service_q <= 16'd1 << acknowledgeVector;
            end else if (state_q == SERVICE && state_d == IDLE) begin
                in_service_q <= '0;
            end
            if (ack_taken && (acknowledgeVector != vector_q)) begin
                ack_error_q <= 1'b1;
            end else if (write_status && regWriteData[0]) begin
                ack_error_q <= 1'b0;
            end
        end
    end

    assign interruptRequest = (state_q == REQUEST);
    assign interruptVector  = vector_q;

    always_comb begin
        regReadData = '0;
        case (regAddr)
            ADDR_MASK:      regReadData = mask_q;
            ADDR_PENDING:   regReadData = pending;
            ADDR_INSERVICE: regReadData = in_service_q;
            ADDR_EDGE:      regReadData = edge_reg;
            ADDR_STATUS:    regReadData = {13'd0, state_q, ack_error_q};
            default:        regReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a randomized run
// against a delay-queue reference model of pending, handshake and register behaviour.
module tb_irq_controller;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] irq_sources = '0;
    logic        irq_req;
    logic [3:0]  irq_vec;
    logic        ack = 1'b0;
    logic [3:0]  ack_vec = '0;
    logic [2:0]  reg_addr = '0;
    logic        reg_write = 1'b0;
    logic [15:0] reg_write_data = '0;
    logic [15:0] reg_read_data;

    int total = 0;
    int bad   = 0;

    irq_controller #(.SYNC_STAGES(SYNC)) dut (
        .clk                  (clk),
        .reset                (reset),
        .irqSources           (irq_sources),
        .interruptRequest     (irq_req),
        .interruptVector      (irq_vec),
        .interruptAcknowledge (ack),
        .acknowledgeVector    (ack_vec),
        .regAddr              (reg_addr),
        .regWrite             (reg_write),
        .regWriteData         (reg_write_data),
        .regReadData          (reg_read_data)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 requesting, 2 in service.
    int          m_mode, m_vec;
    logic [15:0] m_mask, m_insvc, m_pend, m_edge, m_latched;
    logic        m_err, m_eoi_due, t_eoi, t_acked;
    logic [15:0] t_cand;
    logic [15:0] hist [$];

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    // source value sampled d edges ago
    function automatic logic [15:0] delayed(input int d);
        if (hist.size() > d) return hist[hist.size() - 1 - d];
        return 16'h0;
    endfunction

    function automatic logic [15:0] exp_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_mask;
            3'd1:    return m_pend;
            3'd2:    return m_insvc;
            3'd4:    return m_edge;
            3'd5:    return {13'd0, 2'(m_mode), m_err};
            default: return 16'h0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_vec = 0; m_mask = '0; m_insvc = '0; m_pend = '0;
            m_edge = '0; m_latched = '0; m_err = 1'b0; m_eoi_due = 1'b0;
            hist.delete();
        end else begin
            t_cand  = m_pend & m_mask;
            t_eoi   = reg_write && reg_addr == 3'd3 && m_mode == 2;
            t_acked = 1'b0;
            if (m_mode == 0) begin
                if (t_cand != 0) begin m_mode = 1; m_vec = lowest(t_cand); end
            end else if (m_mode == 1) begin
                if (ack) begin m_mode = 2; m_insvc = 16'd1 << ack_vec; t_acked = 1'b1; end
            end else if (m_eoi_due) begin
                m_mode = 0; m_insvc = '0;
            end
            m_eoi_due = t_eoi;
            if (t_acked && int'(ack_vec) != m_vec) m_err = 1'b1;
            else if (reg_write && reg_addr == 3'd5 && reg_write_data[0]) m_err = 1'b0;
            hist.push_back(irq_sources);
            if (hist.size() > 8) void'(hist.pop_front());
`ifdef IRQ_EDGE_TRIGGER_EN
            begin
                logic [15:0] clr;
                clr = (reg_write && reg_addr == 3'd1) ? reg_write_data : 16'h0;
                if (t_acked) clr[ack_vec] = 1'b1;
                m_latched = ((m_latched & ~clr) | (delayed(SYNC) & ~delayed(SYNC + 1))) & m_edge;
                if (reg_write && reg_addr == 3'd4) m_edge = reg_write_data;
            end
`endif
            if (reg_write && reg_addr == 3'd0) m_mask = reg_write_data;
            m_pend = (m_edge & m_latched) | (~m_edge & delayed(SYNC));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        irq_sources = '0; ack = 1'b0; ack_vec = '0;
        reg_write = 1'b0; reg_addr = '0; reg_write_data = '0;
        reset = 1'b1; tick(2); reset = 1'b0; tick(1);
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        reg_addr = a; reg_write_data = d; reg_write = 1'b1; tick(1); reg_write = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
        reg_addr = a; #1; d = reg_read_data;
    endtask

    task automatic acknowledge(input logic [3:0] v);
        ack = 1'b1; ack_vec = v; tick(1); ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        reset = 1'b1; irq_sources = 16'hFFFF; tick(3);
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b expected 0", irq_req); end
        total++; if (irq_vec !== 4'd0) begin bad++; $display("FAIL reset_vec: got %0d expected 0", irq_vec); end
        for (int a = 0; a < 8; a++) begin
            read_reg(3'(a), rd);
            total++; if (rd !== 16'h0) begin bad++; $display("FAIL reset_reg%0d: got %h expected 0000", a, rd); end
        end
        reset = 1'b0; irq_sources = '0; tick(1);
    endtask

    task automatic test_basic();
        logic [15:0] rd;
        reset_dut(); write_reg(3'd0, 16'h0010);
        irq_sources = 16'h0010;
        tick(3);
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL basic_early: got %b expected 0", irq_req); end
        tick(1);
        total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL basic_req: got %b expected 1", irq_req); end
        total++; if (irq_vec !== 4'd4) begin bad++; $display("FAIL basic_vec: got %0d expected 4", irq_vec); end
        acknowledge(4'd4);
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL basic_drop: got %b expected 0", irq_req); end
        read_reg(3'd2, rd);
        total++; if (rd !== 16'h0010) begin bad++; $display("FAIL basic_insvc: got %h expected 0010", rd); end
        read_reg(3'd5, rd);
        total++; if (rd !== 16'h0004) begin bad++; $display("FAIL basic_status: got %h expected 0004", rd); end
        acknowledge(4'd7);
        read_reg(3'd2, rd);
        total++; if (rd !== 16'h0010) begin bad++; $display("FAIL stray_ack_insvc: got %h expected 0010", rd); end
        write_reg(3'd3, 16'h0);
        tick(1);
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL eoi_e1_req: got %b expected 0", irq_req); end
        read_reg(3'd2, rd);
        total++; if (rd !== 16'h0) begin bad++; $display("FAIL eoi_insvc: got %h expected 0000", rd); end
        tick(1);
        total++; if (irq_req !== 1'b1 || irq_vec !== 4'd4) begin bad++; $display("FAIL eoi_e2_req: got %b/%0d expected 1/4", irq_req, irq_vec); end
    endtask

    task automatic test_priority();
        reset_dut(); write_reg(3'd0, 16'hFFFF);
        irq_sources = 16'h0204; tick(4);
        total++; if (irq_req !== 1'b1 || irq_vec !== 4'd2) begin bad++; $display("FAIL prio_first: got %b/%0d expected 1/2", irq_req, irq_vec); end
        acknowledge(4'd2); irq_sources = 16'h0200; tick(4);
        write_reg(3'd3, 16'h0); tick(1);
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL prio_gap: got %b expected 0", irq_req); end
        tick(1);
        total++; if (irq_req !== 1'b1 || irq_vec !== 4'd9) begin bad++; $display("FAIL prio_second: got %b/%0d expected 1/9", irq_req, irq_vec); end
    endtask

    task automatic test_no_preempt();
        reset_dut(); write_reg(3'd0, 16'hFFFF);
        irq_sources = 16'h0200; tick(4);
        irq_sources = 16'h0201;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            total++; if (irq_req !== 1'b1 || irq_vec !== 4'd9) begin bad++; $display("FAIL hold_vec%0d: got %b/%0d expected 1/9", i, irq_req, irq_vec); end
        end
        acknowledge(4'd9);
        write_reg(3'd3, 16'h0); tick(2);
        total++; if (irq_req !== 1'b1 || irq_vec !== 4'd0) begin bad++; $display("FAIL after_eoi_vec: got %b/%0d expected 1/0", irq_req, irq_vec); end
    endtask

    task automatic test_service_block();
        logic [15:0] rd;
        reset_dut(); write_reg(3'd0, 16'hFFFF);
        irq_sources = 16'h0010; tick(4);
        acknowledge(4'd4); irq_sources = 16'h0002;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL svc_block%0d: got %b expected 0", i, irq_req); end
        end
        read_reg(3'd5, rd);
        total++; if (rd !== 16'h0004) begin bad++; $display("FAIL svc_status: got %h expected 0004", rd); end
        write_reg(3'd3, 16'h0); tick(2);
        total++; if (irq_req !== 1'b1 || irq_vec !== 4'd1) begin bad++; $display("FAIL svc_next: got %b/%0d expected 1/1", irq_req, irq_vec); end
        acknowledge(4'd1); irq_sources = '0; tick(4);
        write_reg(3'd3, 16'h0); tick(2);
        write_reg(3'd3, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            read_reg(3'd5, rd);
            total++; if (rd !== 16'h0000 || irq_req !== 1'b0) begin bad++; $display("FAIL idle_eoi%0d: got %h/%b expected 0000/0", i, rd, irq_req); end
        end
    endtask

    task automatic test_ack_error();
        logic [15:0] rd;
        reset_dut(); write_reg(3'd0, 16'h0010);
        irq_sources = 16'h0010; tick(4);
        acknowledge(4'd5);
        read_reg(3'd2, rd);
        total++; if (rd !== 16'h0020) begin bad++; $display("FAIL ackerr_insvc: got %h expected 0020", rd); end
        read_reg(3'd5, rd);
        total++; if (rd !== 16'h0005) begin bad++; $display("FAIL ackerr_set: got %h expected 0005", rd); end
        write_reg(3'd5, 16'h0000);
        read_reg(3'd5, rd);
        total++; if (rd !== 16'h0005) begin bad++; $display("FAIL ackerr_sticky: got %h expected 0005", rd); end
        write_reg(3'd5, 16'h0001);
        read_reg(3'd5, rd);
        total++; if (rd !== 16'h0004) begin bad++; $display("FAIL ackerr_clear: got %h expected 0004", rd); end
    endtask

    task automatic test_registers();
        logic [15:0] rd, d;
        reset_dut();
        d = 16'($urandom);
        write_reg(3'd0, d);
        read_reg(3'd0, rd);
        total++; if (rd !== d) begin bad++; $display("FAIL mask_rw: got %h expected %h", rd, d); end
        write_reg(3'd0, 16'h0);
        write_reg(3'd6, 16'hFFFF); write_reg(3'd7, 16'hFFFF);
        for (int a = 6; a < 8; a++) begin
            read_reg(3'(a), rd);
            total++; if (rd !== 16'h0) begin bad++; $display("FAIL reg%0d_zero: got %h expected 0000", a, rd); end
        end
        read_reg(3'd0, rd);
        total++; if (rd !== 16'h0) begin bad++; $display("FAIL mask_untouched: got %h expected 0000", rd); end
        irq_sources = 16'h00F0; tick(4);
        read_reg(3'd1, rd);
        total++; if (rd !== 16'h00F0) begin bad++; $display("FAIL masked_pending: got %h expected 00f0", rd); end
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL masked_req: got %b expected 0", irq_req); end
        write_reg(3'd1, 16'hFFFF);
        read_reg(3'd1, rd);
        total++; if (rd !== 16'h00F0) begin bad++; $display("FAIL level_w1c: got %h expected 00f0", rd); end
`ifndef IRQ_EDGE_TRIGGER_EN
        write_reg(3'd4, 16'hFFFF);
        read_reg(3'd4, rd);
        total++; if (rd !== 16'h0) begin bad++; $display("FAIL edge_absent: got %h expected 0000", rd); end
`endif
    endtask

`ifdef IRQ_EDGE_TRIGGER_EN
    task automatic test_edge();
        logic [15:0] rd;
        reset_dut(); write_reg(3'd4, 16'h0008);
        irq_sources = 16'h0008; tick(1); irq_sources = '0; tick(5);
        read_reg(3'd1, rd);
        total++; if (rd !== 16'h0008) begin bad++; $display("FAIL edge_latch: got %h expected 0008", rd); end
        write_reg(3'd1, 16'h0008);
        read_reg(3'd1, rd);
        total++; if (rd !== 16'h0) begin bad++; $display("FAIL edge_w1c: got %h expected 0000", rd); end
        irq_sources = 16'h0008; tick(1); irq_sources = '0; tick(1);
        write_reg(3'd1, 16'h0008);
        read_reg(3'd1, rd);
        total++; if (rd !== 16'h0008) begin bad++; $display("FAIL edge_set_wins: got %h expected 0008", rd); end
        write_reg(3'd0, 16'h0008); tick(1);
        total++; if (irq_req !== 1'b1 || irq_vec !== 4'd3) begin bad++; $display("FAIL edge_req: got %b/%0d expected 1/3", irq_req, irq_vec); end
        acknowledge(4'd3);
        read_reg(3'd1, rd);
        total++; if (rd !== 16'h0) begin bad++; $display("FAIL edge_ack_clear: got %h expected 0000", rd); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [15:0] rd;
        reset_dut(); write_reg(3'd0, 16'hFFFF);
        irq_sources = 16'h0100; tick(4);
        total++; if (irq_req !== 1'b1 || irq_vec !== 4'd8) begin bad++; $display("FAIL mid_req: got %b/%0d expected 1/8", irq_req, irq_vec); end
        #2; reset = 1'b1; #1;
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL mid_reset_req: got %b expected 0", irq_req); end
        read_reg(3'd1, rd);
        total++; if (rd !== 16'h0) begin bad++; $display("FAIL mid_reset_pend: got %h expected 0000", rd); end
        read_reg(3'd5, rd);
        total++; if (rd !== 16'h0) begin bad++; $display("FAIL mid_reset_status: got %h expected 0000", rd); end
        tick(1); reset = 1'b0; irq_sources = '0; tick(1);
    endtask

    task automatic test_random();
        reset_dut();
        for (int cyc = 0; cyc < 600; cyc++) begin
            total++; if (irq_req !== (m_mode == 1)) begin bad++; $display("FAIL rand_req@%0d: got %b expected %b", cyc, irq_req, m_mode == 1); end
            if (m_mode == 1) begin
                total++; if (irq_vec !== 4'(m_vec)) begin bad++; $display("FAIL rand_vec@%0d: got %0d expected %0d", cyc, irq_vec, m_vec); end
            end
            total++; if (reg_read_data !== exp_read(reg_addr)) begin bad++; $display("FAIL rand_read%0d@%0d: got %h expected %h", reg_addr, cyc, reg_read_data, exp_read(reg_addr)); end
            ack = 1'b0; reg_write = 1'b0; ack_vec = 4'($urandom);
            if ($urandom_range(0, 5) == 0) irq_sources = irq_sources ^ (16'd1 << $urandom_range(0, 15));
            if (m_mode == 1 && $urandom_range(0, 3) == 0) begin
                ack = 1'b1;
                if ($urandom_range(0, 7) != 0) ack_vec = 4'(m_vec);
            end else if ($urandom_range(0, 15) == 0) begin
                ack = 1'b1;
            end
            reg_write_data = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       begin reg_write = 1'b1; reg_addr = 3'd0; end
                1, 2:    begin reg_write = 1'b1; reg_addr = 3'd3; end
                3:       begin reg_write = 1'b1; reg_addr = 3'd5; end
                4:       begin reg_write = 1'b1; reg_addr = 3'd1; end
                5:       begin reg_write = 1'b1; reg_addr = 3'd4; end
                default: reg_addr = 3'($urandom_range(0, 7));
            endcase
            tick(1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_no_preempt();
        test_service_block();
        test_ack_error();
        test_registers();
`ifdef IRQ_EDGE_TRIGGER_EN
        test_edge();
`endif
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "watchdog");
    end

endmodule
